id_stage_pipe: RTL and testbench

Parametrised successor to the combinational decode stage. Decodes the IF/ID instruction, reads the internal register file with write-first bypass, detects load-use hazards, and predicts branches with a configurable 2-bit branch history table (BHT). All decoded fields and control are captured in an internal ID/EX register, so EX sees registered values with a valid bit. Sits between the IF/ID register and the EX stage and feeds the redirect path back to IF.

---
 rtl/id_stage_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered instruction-decode stage.
// Decodes the IF/ID instruction, reads a 32x32 register file with write-first
// bypass from WB, detects load-use hazards, raises fetch redirects for jumps
// and predicted-taken branches, and captures everything into an ID/EX register.
// Optional feature: define ID_BHT_EN to enable dynamic branch prediction with a
// BHT of 2-bit saturating counters. Without it, branches are predicted not-taken.
module id_stage_pipe #(
  parameter int BHT_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_next_pc,
  input  logic [31:0] i_instruction,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_reg_write,
  input  logic [4:0]  i_write_register,
  input  logic [31:0] i_write_data,
  input  logic        i_bu_valid,
  input  logic [31:0] i_bu_pc,
  input  logic        i_bu_taken,
  output logic        o_hazard_stall,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_read_data_1,
  output logic [31:0] o_read_data_2,
  output logic [31:0] o_sign_extended_imm,
  output logic [31:0] o_next_pc,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [5:0]  o_opcode,
  output logic [5:0]  o_function,
  output logic [8:0]  o_ctrl,
  output logic        o_pred_taken
);

  localparam int IDX = $clog2(BHT_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // Control word bit order: {alu_src, alu_op[1:0], reg_dst, reg_write,
  //                          mem_read, mem_write, mem_to_reg, branch}
  localparam int CTRL_MEM_READ = 3;

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_function;
  logic [31:0] w_imm_ext;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_read_data_1;
  logic [31:0] w_read_data_2;
  logic [8:0]  w_ctrl;
  logic        w_is_branch;
  logic        w_is_jump;
  logic        w_pred;
  logic        w_issue;
  logic        w_bubble;

  assign w_opcode   = i_instruction[31:26];
  assign w_rs       = i_instruction[25:21];
  assign w_rt       = i_instruction[20:16];
  assign w_rd       = i_instruction[15:11];
  assign w_function = i_instruction[5:0];

  assign w_imm_ext       = {{16{i_instruction[15]}}, i_instruction[15:0]};
  assign w_branch_target = i_next_pc + (w_imm_ext << 2);
  assign w_jump_target   = {i_next_pc[31:28], i_instruction[25:0], 2'b00};

  assign w_is_branch = (w_opcode == OP_BEQ) || (w_opcode == OP_BNE);
  assign w_is_jump   = (w_opcode == OP_J);

  // Main decoder: opcode to control word; unknown opcodes decode as NOP.
  always_comb begin
    // NOTE: default assigned first so every path drives w_ctrl and no latch is inferred.
    w_ctrl = '0;
    case (w_opcode)
      OP_RTYPE:       w_ctrl = 9'b0_10_1_1_0_0_0_0;
      OP_LW:          w_ctrl = 9'b1_00_0_1_1_0_1_0;
      OP_SW:          w_ctrl = 9'b1_00_0_0_0_1_0_0;
      OP_BEQ, OP_BNE: w_ctrl = 9'b0_01_0_0_0_0_0_1;
      OP_ADDI:        w_ctrl = 9'b1_00_0_1_0_0_0_0;
      default:        w_ctrl = '0;
    endcase
  end

  logic [31:0] r_rf [32];

  // Register file write port; r0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    // NOTE: the register file is cleared on reset because software may read
    // architected registers before writing them; this keeps it in flops, not RAM.
    if (reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (i_reg_write && (i_write_register != 5'd0)) begin
      r_rf[i_write_register] <= i_write_data;
    end
  end

  // Write-first bypass: a same-cycle WB write to the read index wins.
  assign w_read_data_1 = (w_rs == 5'd0) ? '0 :
                         (i_reg_write && (i_write_register == w_rs)) ? i_write_data : r_rf[w_rs];
  assign w_read_data_2 = (w_rt == 5'd0) ? '0 :
                         (i_reg_write && (i_write_register == w_rt)) ? i_write_data : r_rf[w_rt];

`ifdef ID_BHT_EN
  logic [1:0]     r_bht [BHT_DEPTH];
  logic [IDX-1:0] w_lookup_idx;
  logic [IDX-1:0] w_update_idx;

  // Lookup indexes by the instruction's own PC (next_pc - 4).
  assign w_lookup_idx = IDX'((i_next_pc - 32'd4) >> 2);
  assign w_update_idx = IDX'(i_bu_pc >> 2);

  // BHT counters: reset weakly not-taken, saturating update from EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
    end else if (i_bu_valid) begin
      if (i_bu_taken) begin
        if (r_bht[w_update_idx] != 2'b11) r_bht[w_update_idx] <= r_bht[w_update_idx] + 2'd1;
      end else begin
        if (r_bht[w_update_idx] != 2'b00) r_bht[w_update_idx] <= r_bht[w_update_idx] - 2'd1;
      end
    end
  end

  // Same-cycle lookup reads the pre-update counter.
  assign w_pred = r_bht[w_lookup_idx][1];
`else
  logic w_unused_bu;

  assign w_unused_bu = ^{i_bu_valid, i_bu_taken, i_bu_pc};
  assign w_pred      = 1'b0;
`endif

  // Load-use hazard: the load in ID/EX targets a register this instruction reads.
  assign o_hazard_stall = o_valid & o_ctrl[CTRL_MEM_READ] & (o_rt != 5'd0) & i_valid &
                          ((o_rt == w_rs) | (o_rt == w_rt));

  assign w_issue  = i_valid & ~o_hazard_stall & ~i_flush & ~i_stall;
  assign w_bubble = i_flush | o_hazard_stall | ~i_valid;

  // Fetch redirect for jumps and predicted-taken branches that actually issue.
  always_comb begin
    o_redirect    = 1'b0;
    o_redirect_pc = '0;
    if (w_issue) begin
      if (w_is_jump) begin
        o_redirect    = 1'b1;
        o_redirect_pc = w_jump_target;
      end else if (w_is_branch && w_pred) begin
        o_redirect    = 1'b1;
        o_redirect_pc = w_branch_target;
      end
    end
  end

  // ID/EX register: stall holds, squash/hazard/invalid inserts a bubble.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      o_valid             <= 1'b0;
      o_read_data_1       <= '0;
      o_read_data_2       <= '0;
      o_sign_extended_imm <= '0;
      o_next_pc           <= '0;
      o_rs                <= '0;
      o_rt                <= '0;
      o_rd                <= '0;
      o_opcode            <= '0;
      o_function          <= '0;
      o_ctrl              <= '0;
      o_pred_taken        <= 1'b0;
    end else if (!i_stall) begin
      o_read_data_1       <= w_read_data_1;
      o_read_data_2       <= w_read_data_2;
      o_sign_extended_imm <= w_imm_ext;
      o_next_pc           <= i_next_pc;
      o_rs                <= w_rs;
      o_rt                <= w_rt;
      o_rd                <= w_rd;
      o_opcode            <= w_opcode;
      o_function          <= w_function;
      o_pred_taken        <= w_is_branch & w_pred;
      o_valid             <= ~w_bubble;
      o_ctrl              <= w_bubble ? 9'd0 : w_ctrl;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Testbench for id_stage_pipe: directed scenarios plus a randomized run
// checked against a behavioural model of the decode stage.
module tb_id_stage_pipe;
  localparam int DEPTH = 16;
`ifdef ID_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_next_pc;
  logic [31:0] i_instruction;
  logic        i_stall;
  logic        i_flush;
  logic        i_reg_write;
  logic [4:0]  i_write_register;
  logic [31:0] i_write_data;
  logic        i_bu_valid;
  logic [31:0] i_bu_pc;
  logic        i_bu_taken;
  logic        o_hazard_stall;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_valid;
  logic [31:0] o_read_data_1;
  logic [31:0] o_read_data_2;
  logic [31:0] o_sign_extended_imm;
  logic [31:0] o_next_pc;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [5:0]  o_opcode;
  logic [5:0]  o_function;
  logic [8:0]  o_ctrl;
  logic        o_pred_taken;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] npc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [8:0]  ctrl;
    logic        pred;
  } exp_t;

  id_stage_pipe #(.BHT_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_valid             (i_valid),
    .i_next_pc           (i_next_pc),
    .i_instruction       (i_instruction),
    .i_stall             (i_stall),
    .i_flush             (i_flush),
    .i_reg_write         (i_reg_write),
    .i_write_register    (i_write_register),
    .i_write_data        (i_write_data),
    .i_bu_valid          (i_bu_valid),
    .i_bu_pc             (i_bu_pc),
    .i_bu_taken          (i_bu_taken),
    .o_hazard_stall      (o_hazard_stall),
    .o_redirect          (o_redirect),
    .o_redirect_pc       (o_redirect_pc),
    .o_valid             (o_valid),
    .o_read_data_1       (o_read_data_1),
    .o_read_data_2       (o_read_data_2),
    .o_sign_extended_imm (o_sign_extended_imm),
    .o_next_pc           (o_next_pc),
    .o_rs                (o_rs),
    .o_rt                (o_rt),
    .o_rd                (o_rd),
    .o_opcode            (o_opcode),
    .o_function          (o_function),
    .o_ctrl              (o_ctrl),
    .o_pred_taken        (o_pred_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  // Control word straight from the decode table.
  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:        return 9'b0_10_1_1_0_0_0_0;
      6'h23:        return 9'b1_00_0_1_1_0_1_0;
      6'h2B:        return 9'b1_00_0_0_0_1_0_0;
      6'h04, 6'h05: return 9'b0_01_0_0_0_0_0_1;
      6'h08:        return 9'b1_00_0_1_0_0_0_0;
      default:      return 9'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    i_valid = 0; i_next_pc = 0; i_instruction = 0; i_stall = 0; i_flush = 0;
    i_reg_write = 0; i_write_register = 0; i_write_data = 0;
    i_bu_valid = 0; i_bu_pc = 0; i_bu_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++;
    if (o_ctrl !== 9'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", o_ctrl); end
    n_checks++;
    if ({o_read_data_1, o_read_data_2, o_sign_extended_imm, o_next_pc} !== 128'd0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", o_read_data_1, o_read_data_2, o_sign_extended_imm, o_next_pc);
    end
    n_checks++;
    if ({o_rs, o_rt, o_rd, o_opcode, o_function, o_pred_taken} !== 28'd0) begin
      n_fail++; $display("FAIL reset_fields: got %h %h %h %h %h %b want 0", o_rs, o_rt, o_rd, o_opcode, o_function, o_pred_taken);
    end
    n_checks++;
    if ({o_hazard_stall, o_redirect, o_redirect_pc} !== 34'd0) begin
      n_fail++; $display("FAIL reset_comb: got %b %b %h want 0", o_hazard_stall, o_redirect, o_redirect_pc);
    end
    n_checks++;
    // Write r7, set up a load-use hazard, then reset mid-stall.
    i_reg_write = 1; i_write_register = 7; i_write_data = 32'h1234_5678;
    i_valid = 1; i_next_pc = 32'h10; i_instruction = enc_i(6'h23, 1, 7, 16'h0);
    step();
    i_reg_write = 0;
    i_instruction = enc_r(7, 0, 8, 6'h20);
    #1;
    if (o_hazard_stall !== 1'b1) begin n_fail++; $display("FAIL reset_pre_hazard: got %b want 1", o_hazard_stall); end
    n_checks++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    if (o_valid !== 1'b0 || o_hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_stall: got valid %b hazard %b want 0 0", o_valid, o_hazard_stall);
    end
    n_checks++;
    step();
    if (o_read_data_1 !== 32'd0 || o_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_rf_clear: got valid %b data %h want 1 00000000", o_valid, o_read_data_1);
    end
    n_checks++;
  endtask

  task automatic test_load_use();
    do_reset();
    i_valid = 1; i_next_pc = 32'h104; i_instruction = enc_i(6'h23, 1, 2, 16'h0);
    #1;
    if (o_hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_no_hazard: got %b want 0", o_hazard_stall); end
    n_checks++;
    step();
    if (o_valid !== 1'b1 || o_ctrl !== 9'h11A || o_rt !== 5'd2) begin
      n_fail++; $display("FAIL lu_load: got valid %b ctrl %h rt %0d want 1 11a 2", o_valid, o_ctrl, o_rt);
    end
    n_checks++;
    i_next_pc = 32'h108; i_instruction = enc_r(2, 4, 3, 6'h20);
    #1;
    if (o_hazard_stall !== 1'b1 || o_redirect !== 1'b0) begin
      n_fail++; $display("FAIL lu_hazard: got hazard %b redirect %b want 1 0", o_hazard_stall, o_redirect);
    end
    n_checks++;
    step();
    if (o_valid !== 1'b0 || o_ctrl !== 9'd0) begin
      n_fail++; $display("FAIL lu_bubble: got valid %b ctrl %h want 0 000", o_valid, o_ctrl);
    end
    n_checks++;
    if (o_hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_hazard_drop: got %b want 0", o_hazard_stall); end
    n_checks++;
    step();
    if (o_valid !== 1'b1 || o_ctrl !== 9'h0B0 || o_rd !== 5'd3 || o_rs !== 5'd2 || o_rt !== 5'd4 || o_function !== 6'h20) begin
      n_fail++; $display("FAIL lu_add: got valid %b ctrl %h rs %0d rt %0d rd %0d fn %h want 1 0b0 2 4 3 20",
                         o_valid, o_ctrl, o_rs, o_rt, o_rd, o_function);
    end
    n_checks++;
  endtask

  task automatic test_bypass();
    do_reset();
    i_valid = 1; i_next_pc = 32'h20; i_instruction = enc_r(5, 0, 6, 6'h20);
    i_reg_write = 1; i_write_register = 5; i_write_data = 32'hDEAD_BEEF;
    step();
    if (o_read_data_1 !== 32'hDEAD_BEEF || o_read_data_2 !== 32'd0) begin
      n_fail++; $display("FAIL bypass_rs: got %h %h want deadbeef 00000000", o_read_data_1, o_read_data_2);
    end
    n_checks++;
    i_instruction = enc_r(0, 5, 7, 6'h22);
    i_write_register = 0; i_write_data = 32'h1234_5678;
    step();
    if (o_read_data_1 !== 32'd0) begin n_fail++; $display("FAIL bypass_r0: got %h want 00000000", o_read_data_1); end
    n_checks++;
    if (o_read_data_2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rf_commit: got %h want deadbeef", o_read_data_2); end
    n_checks++;
    i_reg_write = 0;
    step();
    if (o_read_data_1 !== 32'd0) begin n_fail++; $display("FAIL r0_after_write: got %h want 00000000", o_read_data_1); end
    n_checks++;
  endtask

  task automatic test_jump_flush();
    do_reset();
    i_valid = 1; i_next_pc = 32'h8000_0004; i_instruction = enc_j(26'h100);
    #1;
    if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h8000_0400) begin
      n_fail++; $display("FAIL jump_redirect: got %b %h want 1 80000400", o_redirect, o_redirect_pc);
    end
    n_checks++;
    step();
    if (o_valid !== 1'b1 || o_ctrl !== 9'd0 || o_opcode !== 6'h02) begin
      n_fail++; $display("FAIL jump_capture: got valid %b ctrl %h op %h want 1 000 02", o_valid, o_ctrl, o_opcode);
    end
    n_checks++;
    i_flush = 1;
    #1;
    if (o_redirect !== 1'b0 || o_redirect_pc !== 32'd0) begin
      n_fail++; $display("FAIL jump_flush_redirect: got %b %h want 0 00000000", o_redirect, o_redirect_pc);
    end
    n_checks++;
    step();
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL jump_flush_valid: got %b want 0", o_valid); end
    n_checks++;
  endtask

  task automatic test_stall();
    do_reset();
    i_valid = 1; i_next_pc = 32'h200; i_instruction = enc_i(6'h08, 1, 9, 16'hFFF0);
    step();
    for (int k = 0; k < 3; k++) begin
      i_stall = 1;
      i_next_pc = {4'($urandom), 26'($urandom), 2'b00};
      i_instruction = enc_j(26'($urandom));
      #1;
      if (o_redirect !== 1'b0) begin n_fail++; $display("FAIL stall_redirect[%0d]: got %b want 0", k, o_redirect); end
      n_checks++;
      step();
      if (o_valid !== 1'b1 || o_ctrl !== 9'h110 || o_sign_extended_imm !== 32'hFFFF_FFF0 ||
          o_next_pc !== 32'h200 || o_rt !== 5'd9 || o_opcode !== 6'h08) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid %b ctrl %h imm %h npc %h rt %0d op %h", k,
                           o_valid, o_ctrl, o_sign_extended_imm, o_next_pc, o_rt, o_opcode);
      end
      n_checks++;
    end
  endtask

  task automatic test_bht();
    do_reset();
    i_bu_valid = 1; i_bu_pc = 32'h40; i_bu_taken = 1;
    repeat (2) step();
    i_bu_valid = 0;
    i_valid = 1; i_next_pc = 32'h44; i_instruction = enc_i(6'h04, 1, 2, 16'd3);
    #1;
    if (o_redirect !== BHT_ON || o_redirect_pc !== (BHT_ON ? 32'h50 : 32'h0)) begin
      n_fail++; $display("FAIL bht_beq_redirect: got %b %h want %b %h", o_redirect, o_redirect_pc, BHT_ON, BHT_ON ? 32'h50 : 32'h0);
    end
    n_checks++;
    step();
    if (o_pred_taken !== BHT_ON || o_ctrl !== 9'h041 || o_sign_extended_imm !== 32'd3) begin
      n_fail++; $display("FAIL bht_beq_capture: got pred %b ctrl %h imm %h want %b 041 00000003", o_pred_taken, o_ctrl, o_sign_extended_imm, BHT_ON);
    end
    n_checks++;
    i_valid = 0; i_bu_valid = 1; i_bu_taken = 1;
    repeat (4) step();
    // Counter saturated at 3; update to 2 while looking up the same index.
    i_bu_taken = 0;
    i_valid = 1; i_instruction = enc_i(6'h05, 3, 4, 16'd3);
    #1;
    if (o_redirect !== BHT_ON) begin n_fail++; $display("FAIL bht_old_3: got %b want %b", o_redirect, BHT_ON); end
    n_checks++;
    step();
    i_bu_valid = 0;
    #1;
    if (o_redirect !== BHT_ON) begin n_fail++; $display("FAIL bht_cnt_2: got %b want %b", o_redirect, BHT_ON); end
    n_checks++;
    i_bu_valid = 1;
    #1;
    if (o_redirect !== BHT_ON) begin n_fail++; $display("FAIL bht_old_2: got %b want %b", o_redirect, BHT_ON); end
    n_checks++;
    step();
    i_bu_valid = 0;
    #1;
    if (o_redirect !== 1'b0 || o_redirect_pc !== 32'd0) begin
      n_fail++; $display("FAIL bht_cnt_1: got %b %h want 0 00000000", o_redirect, o_redirect_pc);
    end
    n_checks++;
    step();
    if (o_pred_taken !== 1'b0 || o_opcode !== 6'h05) begin
      n_fail++; $display("FAIL bht_pred_nt: got pred %b op %h want 0 05", o_pred_taken, o_opcode);
    end
    n_checks++;
  endtask

  task automatic test_random();
    exp_t        e;
    exp_t        n;
    logic [31:0] rf_m [32];
    int          bht_m [DEPTH];
    logic [5:0]  ops [8];
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] simm;
    logic [31:0] exp_pc;
    logic        hz;
    logic        pred;
    logic        is_br;
    logic        exp_red;
    int          idx;
    int          k;

    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3F};
    do_reset();
    e = '{default: '0};
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (o_valid !== e.valid) begin n_fail++; $display("FAIL rnd_valid cyc=%0d: got %b want %b", cyc, o_valid, e.valid); end
      n_checks++;
      if (o_ctrl !== e.ctrl) begin n_fail++; $display("FAIL rnd_ctrl cyc=%0d: got %h want %h", cyc, o_ctrl, e.ctrl); end
      n_checks++;
      if (e.valid) begin
        if (o_read_data_1 !== e.rd1 || o_read_data_2 !== e.rd2) begin
          n_fail++; $display("FAIL rnd_rdata cyc=%0d: got %h %h want %h %h", cyc, o_read_data_1, o_read_data_2, e.rd1, e.rd2);
        end
        n_checks++;
        if (o_sign_extended_imm !== e.imm || o_next_pc !== e.npc) begin
          n_fail++; $display("FAIL rnd_imm_pc cyc=%0d: got %h %h want %h %h", cyc, o_sign_extended_imm, o_next_pc, e.imm, e.npc);
        end
        n_checks++;
        if ({o_rs, o_rt, o_rd, o_opcode, o_function} !== {e.rs, e.rt, e.rd, e.op, e.fn}) begin
          n_fail++; $display("FAIL rnd_fields cyc=%0d: got %h %h %h %h %h want %h %h %h %h %h", cyc,
                             o_rs, o_rt, o_rd, o_opcode, o_function, e.rs, e.rt, e.rd, e.op, e.fn);
        end
        n_checks++;
        if (o_pred_taken !== e.pred) begin n_fail++; $display("FAIL rnd_pred cyc=%0d: got %b want %b", cyc, o_pred_taken, e.pred); end
        n_checks++;
      end

      // New random stimulus with small register numbers so hazards occur.
      op = ops[$urandom_range(0, 7)];
      i_instruction = {op, 26'($urandom)};
      i_instruction[25:21] = 5'($urandom_range(0, 7));
      i_instruction[20:16] = 5'($urandom_range(0, 7));
      i_valid = ($urandom_range(0, 99) < 85);
      i_stall = ($urandom_range(0, 99) < 15);
      i_flush = ($urandom_range(0, 99) < 10);
      i_next_pc = {4'($urandom), 20'd0, 6'($urandom), 2'b00};
      i_reg_write = 1'($urandom);
      i_write_register = 5'($urandom_range(0, 7));
      i_write_data = $urandom;
      i_bu_valid = 1'($urandom);
      i_bu_pc = {24'd0, 6'($urandom), 2'b00};
      i_bu_taken = 1'($urandom);
      #1;

      rs = i_instruction[25:21];
      rt = i_instruction[20:16];
      simm = {{16{i_instruction[15]}}, i_instruction[15:0]};
      is_br = (op == 6'h04) || (op == 6'h05);
      hz = e.valid && e.ctrl[3] && (e.rt != 0) && i_valid && ((e.rt == rs) || (e.rt == rt));
      idx = int'(((i_next_pc - 32'd4) >> 2) % DEPTH);
      pred = BHT_ON && (bht_m[idx] >= 2);
      exp_red = i_valid && !hz && !i_flush && !i_stall && ((op == 6'h02) || (is_br && pred));
      exp_pc = !exp_red ? 32'd0 :
               (op == 6'h02) ? {i_next_pc[31:28], i_instruction[25:0], 2'b00} : i_next_pc + simm * 4;

      if (o_hazard_stall !== hz) begin n_fail++; $display("FAIL rnd_hazard cyc=%0d: got %b want %b", cyc, o_hazard_stall, hz); end
      n_checks++;
      if (o_redirect !== exp_red || o_redirect_pc !== exp_pc) begin
        n_fail++; $display("FAIL rnd_redirect cyc=%0d: got %b %h want %b %h", cyc, o_redirect, o_redirect_pc, exp_red, exp_pc);
      end
      n_checks++;

      if (!i_stall) begin
        n.valid = !(i_flush || hz || !i_valid);
        n.ctrl  = n.valid ? ctrl_of(op) : 9'd0;
        n.rd1   = (rs == 0) ? 32'd0 : (i_reg_write && i_write_register == rs) ? i_write_data : rf_m[rs];
        n.rd2   = (rt == 0) ? 32'd0 : (i_reg_write && i_write_register == rt) ? i_write_data : rf_m[rt];
        n.imm   = simm;
        n.npc   = i_next_pc;
        n.rs    = rs;
        n.rt    = rt;
        n.rd    = i_instruction[15:11];
        n.op    = op;
        n.fn    = i_instruction[5:0];
        n.pred  = is_br && pred;
        e = n;
      end
      if (i_reg_write && i_write_register != 0) rf_m[i_write_register] = i_write_data;
      if (BHT_ON && i_bu_valid) begin
        k = int'((i_bu_pc >> 2) % DEPTH);
        if (i_bu_taken) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
        else            bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_bypass();
    test_jump_flush();
    test_stall();
    test_bht();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
